// File: rtl/dcdir_ctl.sv
// dcdir_ctl: controller in front of the L1 D-cache directory array
// (LINES entries of TAG_W+2 bits). It owns every directory read and write and
// serves, in fixed priority, flash-invalidate (flush), reload fills,
// invalidate-by-address and tag lookups. The array shares its address
// between read and write, so at most one operation runs per cycle.
//
// Entry format: [TAG_W+1] valid, [TAG_W] even parity (^tag), [TAG_W-1:0] tag.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   req_val/req_ea/req_rdy     lookup request / accept
//   rsp_val/rsp_hit/rsp_perr   lookup result, one cycle after accept
//   rld_val/rld_ea/rld_rdy     reload fill request / accept
//   inv_val/inv_ea/inv_rdy     invalidate-by-address request / accept
//   inv_done/inv_hit           invalidate completion pulse, line-was-valid flag
//   flush_val/flush_rdy        flash-invalidate request / accept
//   init_done                  directory cleaned once, controller operational
//   dir_rd_adr/dir_rd_dat      array read port (combinational data)
//   dir_wr_en/adr/dat          array write port (enable is all-0 or all-1)
module dcdir_ctl #(
    parameter int LINES  = 128,
    parameter int IDX_W  = 7,
    parameter int OFFS_W = 5,
    parameter int TAG_W  = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_val,
    input  logic [31:0]        req_ea,
    output logic               req_rdy,
    output logic               rsp_val,
    output logic               rsp_hit,
    output logic               rsp_perr,
    input  logic               rld_val,
    input  logic [31:0]        rld_ea,
    output logic               rld_rdy,
    input  logic               inv_val,
    input  logic [31:0]        inv_ea,
    output logic               inv_rdy,
    output logic               inv_done,
    output logic               inv_hit,
    input  logic               flush_val,
    output logic               flush_rdy,
    output logic               init_done,
    output logic [IDX_W-1:0]   dir_rd_adr,
    input  logic [TAG_W+1:0]   dir_rd_dat,
    output logic [3:0]         dir_wr_en,
    output logic [IDX_W-1:0]   dir_wr_adr,
    output logic [TAG_W+1:0]   dir_wr_dat
);

    localparam int ENT_W = TAG_W + 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINES - 1);

    typedef enum logic [1:0] {INIT, IDLE, INV_WR} state_t;

    state_t             state;
    logic [IDX_W-1:0]   cnt;
    logic [IDX_W-1:0]   inv_idx_p1;
    logic               inv_match_p1;
    logic               inv_done_p1;
    logic               inv_hit_p1;

    function automatic logic [IDX_W-1:0] ea_idx(input logic [31:0] ea);
        return ea[OFFS_W+IDX_W-1:OFFS_W];
    endfunction

    function automatic logic [TAG_W-1:0] ea_tag(input logic [31:0] ea);
        return ea[31:OFFS_W+IDX_W];
    endfunction

    // Offset bits never address the directory.
    logic unused_offs;
    assign unused_offs = ^{req_ea[OFFS_W-1:0], rld_ea[OFFS_W-1:0], inv_ea[OFFS_W-1:0]};

    // Fixed priority: flush > reload > invalidate > lookup.
    logic idle;
    assign idle      = (state == IDLE);
    assign flush_rdy = idle;
    assign rld_rdy   = idle && !flush_val;
    assign inv_rdy   = idle && !flush_val && !rld_val;
    assign req_rdy   = idle && !flush_val && !rld_val && !inv_val;

    logic do_flush, do_rld, do_inv, do_req;
    assign do_flush = flush_val && flush_rdy;
    assign do_rld   = rld_val && rld_rdy;
    assign do_inv   = inv_val && inv_rdy;
    assign do_req   = req_val && req_rdy;

    // Decode of the entry currently on the read port.
    logic             ent_valid;
    logic             ent_perr;
    logic             req_tag_eq;
    logic             inv_tag_eq;
    assign ent_valid  = dir_rd_dat[ENT_W-1];
    assign ent_perr   = ent_valid && (^dir_rd_dat[TAG_W:0]);
    assign req_tag_eq = (dir_rd_dat[TAG_W-1:0] == ea_tag(req_ea));
    assign inv_tag_eq = (dir_rd_dat[TAG_W-1:0] == ea_tag(inv_ea));

    // Write port: init clear, invalidate clear, or reload fill.
    logic wr;
    always_comb begin
        wr         = 1'b0;
        dir_wr_adr = cnt;
        dir_wr_dat = '0;
        if (state == INIT) begin
            wr = 1'b1;
        end else if (state == INV_WR) begin
            wr         = inv_match_p1;
            dir_wr_adr = inv_idx_p1;
        end else if (do_rld) begin
            wr         = 1'b1;
            dir_wr_adr = ea_idx(rld_ea);
            dir_wr_dat = {1'b1, ^ea_tag(rld_ea), ea_tag(rld_ea)};
        end
    end

    assign dir_wr_en = {4{wr && !rst}};

    // A write cycle owns the shared address; otherwise read for the
    // invalidate being accepted, defaulting to the lookup index.
    always_comb begin
        if (wr)          dir_rd_adr = dir_wr_adr;
        else if (do_inv) dir_rd_adr = ea_idx(inv_ea);
        else             dir_rd_adr = ea_idx(req_ea);
    end

    // A reset arriving while the invalidate completes swallows its pulse.
    assign inv_done = inv_done_p1 && !rst;
    assign inv_hit  = inv_hit_p1 && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= INIT;
            cnt          <= '0;
            rsp_val      <= 1'b0;
            rsp_hit      <= 1'b0;
            rsp_perr     <= 1'b0;
            inv_done_p1  <= 1'b0;
            inv_hit_p1   <= 1'b0;
            inv_match_p1 <= 1'b0;
            init_done    <= 1'b0;
        end else begin
            rsp_val     <= 1'b0;
            inv_done_p1 <= 1'b0;
            inv_hit_p1  <= 1'b0;
            case (state)
                INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_IDX) begin
                        state     <= IDLE;
                        init_done <= 1'b1;
                    end
                end
                IDLE: begin
                    if (do_flush) begin
                        state <= INIT;
                        cnt   <= '0;
                    end else if (do_inv) begin
                        // Parity is deliberately ignored: a corrupt but matching
                        // line is still removed.
                        inv_idx_p1   <= ea_idx(inv_ea);
                        inv_match_p1 <= ent_valid && inv_tag_eq;
                        inv_done_p1  <= 1'b1;
                        inv_hit_p1   <= ent_valid && inv_tag_eq;
                        state        <= INV_WR;
                    end else if (do_req) begin
                        rsp_val  <= 1'b1;
                        rsp_hit  <= ent_valid && req_tag_eq && !ent_perr;
                        rsp_perr <= ent_perr;
                    end
                end
                INV_WR: state <= IDLE;
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_dcdir_ctl.sv
module tb_dcdir_ctl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_val = 1'b0, rld_val = 1'b0, inv_val = 1'b0, flush_val = 1'b0;
    logic [31:0] req_ea = '0, rld_ea = '0, inv_ea = '0;
    logic        req_rdy, rld_rdy, inv_rdy, flush_rdy;
    logic        rsp_val, rsp_hit, rsp_perr, inv_done, inv_hit, init_done;
    logic [6:0]  dir_rd_adr, dir_wr_adr;
    logic [21:0] dir_rd_dat, dir_wr_dat;
    logic [3:0]  dir_wr_en;

    always #5 clk = ~clk;

    dcdir_ctl dut (
        .clk(clk), .rst(rst),
        .req_val(req_val), .req_ea(req_ea), .req_rdy(req_rdy),
        .rsp_val(rsp_val), .rsp_hit(rsp_hit), .rsp_perr(rsp_perr),
        .rld_val(rld_val), .rld_ea(rld_ea), .rld_rdy(rld_rdy),
        .inv_val(inv_val), .inv_ea(inv_ea), .inv_rdy(inv_rdy),
        .inv_done(inv_done), .inv_hit(inv_hit),
        .flush_val(flush_val), .flush_rdy(flush_rdy), .init_done(init_done),
        .dir_rd_adr(dir_rd_adr), .dir_rd_dat(dir_rd_dat),
        .dir_wr_en(dir_wr_en), .dir_wr_adr(dir_wr_adr), .dir_wr_dat(dir_wr_dat)
    );

    // Directory array: garbage at power-up, written on full enable.
    logic [21:0] mem [128];
    logic        mem_ready = 1'b0;
    logic        force_en = 1'b0;
    logic [21:0] force_dat = '0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int k = 0; k < 128; k++) mem[k] <= 22'($urandom);
            mem_ready <= 1'b1;
        end else if (dir_wr_en == 4'hF) begin
            mem[dir_wr_adr] <= dir_wr_dat;
        end
    end
    assign dir_rd_dat = force_en ? force_dat : mem[dir_rd_adr];

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] ea_idx(input logic [31:0] ea);
        return ea[11:5];
    endfunction
    function automatic logic [19:0] ea_tag(input logic [31:0] ea);
        return ea[31:12];
    endfunction

    // Reference model: logical directory contents plus outstanding work.
    bit          ref_v [128];
    logic [19:0] ref_t [128];
    int          init_left = 128;
    bit          inv_pend = 0;
    logic [6:0]  inv_i = '0;
    bit          inv_h = 0;
    logic        x_rv = 0, x_h = 0, x_p = 0, x_d = 0, x_ih = 0, x_init = 0;
    bit          acc_rld, acc_inv, acc_req;

    // One clock cycle: check registered outputs from the last cycle, predict
    // and check this cycle's combinational outputs, advance the model.
    task automatic step();
        logic e_fr, e_rr, e_ir, e_qr;
        logic [3:0] e_we;
        logic [6:0] e_wa, e_ra, i;
        logic [21:0] e_wd;
        logic [19:0] t;
        logic n_rv, n_h, n_p, n_d, n_ih, n_init;
        @(negedge clk);
        chk("rsp_val", rsp_val, x_rv);
        if (x_rv) begin
            chk("rsp_hit", rsp_hit, x_h);
            chk("rsp_perr", rsp_perr, x_p);
        end
        chk("inv_done", inv_done, x_d && !rst);
        if (x_d && !rst) chk("inv_hit", inv_hit, x_ih);
        chk("init_done", init_done, x_init);

        e_fr = 0; e_rr = 0; e_ir = 0; e_qr = 0;
        e_we = 4'h0; e_wa = '0; e_wd = '0; e_ra = ea_idx(req_ea);
        n_rv = 0; n_h = 0; n_p = 0; n_d = 0; n_ih = 0; n_init = x_init;
        acc_rld = 0; acc_inv = 0; acc_req = 0;
        if (rst) begin
            init_left = 128; inv_pend = 0; n_init = 0;
        end else if (init_left > 0) begin
            e_we = 4'hF; e_wa = 7'(128 - init_left);
            ref_v[e_wa] = 0;
            init_left--;
            if (init_left == 0) n_init = 1;
        end else if (inv_pend) begin
            inv_pend = 0;
            if (inv_h) begin
                e_we = 4'hF; e_wa = inv_i; ref_v[inv_i] = 0;
            end
        end else begin
            e_fr = 1;
            e_rr = !flush_val;
            e_ir = !flush_val && !rld_val;
            e_qr = e_ir && !inv_val;
            if (flush_val) begin
                init_left = 128;
            end else if (rld_val) begin
                acc_rld = 1; i = ea_idx(rld_ea); t = ea_tag(rld_ea);
                e_we = 4'hF; e_wa = i; e_wd = {1'b1, ^t, t};
                ref_v[i] = 1; ref_t[i] = t;
            end else if (inv_val) begin
                acc_inv = 1; i = ea_idx(inv_ea); t = ea_tag(inv_ea);
                inv_pend = 1; inv_i = i; inv_h = ref_v[i] && (ref_t[i] == t);
                n_d = 1; n_ih = inv_h; e_ra = i;
            end else if (req_val) begin
                acc_req = 1; i = ea_idx(req_ea); t = ea_tag(req_ea);
                n_rv = 1;
                if (force_en) begin
                    n_p = force_dat[21] && (^force_dat[20:0]);
                    n_h = force_dat[21] && (force_dat[19:0] == t) && !n_p;
                end else begin
                    n_h = ref_v[i] && (ref_t[i] == t);
                end
            end
        end
        if (!rst) begin
            chk("flush_rdy", flush_rdy, e_fr);
            chk("rld_rdy", rld_rdy, e_rr);
            chk("inv_rdy", inv_rdy, e_ir);
            chk("req_rdy", req_rdy, e_qr);
        end
        chk("dir_wr_en", dir_wr_en, e_we);
        chk("wr_vs_lookup", (dir_wr_en != 0) && req_val && req_rdy, 0);
        if (e_we != 0) begin
            chk("dir_wr_adr", dir_wr_adr, e_wa);
            chk("dir_wr_dat", dir_wr_dat, e_wd);
            chk("rd_adr_tied", dir_rd_adr, e_wa);
        end else if (!rst) begin
            chk("dir_rd_adr", dir_rd_adr, e_ra);
        end
        @(posedge clk); #1;
        x_rv = n_rv; x_h = n_h; x_p = n_p; x_d = n_d; x_ih = n_ih; x_init = n_init;
    endtask

    task automatic idle_in();
        req_val = 0; rld_val = 0; inv_val = 0; flush_val = 0;
    endtask

    typedef struct {
        logic f, r, i, q;
        logic efr, err, eir, eqr;
    } prio_t;
    prio_t tbl [7];

    localparam logic [31:0] EA_A = 32'h1234_50A0;  // idx 5, tag 0x12345
    localparam logic [31:0] EA_B = 32'h1234_60A0;  // idx 5, tag 0x12346
    localparam logic [31:0] EA_C = 32'h0000_1000;  // idx 0, tag 1
    localparam logic [31:0] EA_D = 32'h00AB_C3E0;  // idx 0x1F, tag 0x00ABC

    initial begin
        int c_r, c_i, c_q, writes;
        logic [19:0] ta;

        tbl[0] = '{0,0,0,1, 1,1,1,1};
        tbl[1] = '{0,0,1,0, 1,1,1,0};
        tbl[2] = '{0,0,1,1, 1,1,1,0};
        tbl[3] = '{0,1,0,0, 1,1,0,0};
        tbl[4] = '{0,1,1,1, 1,1,0,0};
        tbl[5] = '{0,1,1,0, 1,1,0,0};
        tbl[6] = '{1,1,1,1, 1,0,0,0};

        // Reset state.
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_val", rsp_val, 0);
        chk("rst_inv_done", inv_done, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_wr_en", dir_wr_en, 0);
        step();
        rst = 0;

        // Init sweep with a lookup pending the whole time.
        req_val = 1; req_ea = EA_A; writes = 0;
        for (int k = 0; k < 128; k++) begin
            #1;
            if (dir_wr_en == 4'hF && dir_wr_adr == 7'(k) && dir_wr_dat == 0) writes++;
            step();
        end
        chk("init_writes", writes, 128);
        chk("init_done_129", init_done, 1);
        idle_in();
        step();

        // Reload then hit, different tag misses.
        rld_val = 1; rld_ea = EA_A; step(); idle_in();
        req_val = 1; req_ea = EA_A; step(); idle_in();
        chk("lookup_A_val", rsp_val, 1);
        chk("lookup_A_hit", rsp_hit, 1);
        req_val = 1; req_ea = EA_B; step(); idle_in();
        chk("lookup_B_hit", rsp_hit, 0);

        // Parity error on a matching valid entry.
        ta = 20'h12345;
        force_en = 1; force_dat = {1'b1, ~(^ta), ta};
        req_val = 1; req_ea = EA_A; step(); idle_in(); force_en = 0;
        chk("perr_flag", rsp_perr, 1);
        chk("perr_hit", rsp_hit, 0);

        // Invalidate resident, then non-resident.
        inv_val = 1; inv_ea = EA_A; step(); idle_in();
        chk("inv_res_done", inv_done, 1);
        chk("inv_res_hit", inv_hit, 1);
        chk("inv_res_we", dir_wr_en, 4'hF);
        chk("inv_res_adr", dir_wr_adr, 5);
        step();
        req_val = 1; req_ea = EA_A; step(); idle_in();
        chk("after_inv_miss", rsp_hit, 0);
        inv_val = 1; inv_ea = EA_C; step(); idle_in();
        chk("inv_non_done", inv_done, 1);
        chk("inv_non_hit", inv_hit, 0);
        chk("inv_non_we", dir_wr_en, 0);
        step();

        // All three requesters at once, each holding until accepted.
        rld_val = 1; rld_ea = EA_A; inv_val = 1; inv_ea = EA_A; req_val = 1; req_ea = EA_A;
        c_r = -1; c_i = -1; c_q = -1;
        for (int k = 0; k < 8; k++) begin
            step();
            if (acc_rld) begin c_r = k; rld_val = 0; end
            if (acc_inv) begin c_i = k; inv_val = 0; end
            if (acc_req) begin c_q = k; req_val = 0; chk("order_lookup_miss", rsp_hit, 0); end
        end
        chk("order_rld", c_r, 0);
        chk("order_inv", c_i, 1);
        chk("order_req", c_q, 3);
        idle_in();

        // Priority table, applied from IDLE.
        for (int n = 0; n < 7; n++) begin
            flush_val = tbl[n].f; rld_val = tbl[n].r; inv_val = tbl[n].i; req_val = tbl[n].q;
            rld_ea = EA_D; inv_ea = EA_C; req_ea = EA_D;
            #1;
            chk("tbl_flush_rdy", flush_rdy, tbl[n].efr);
            chk("tbl_rld_rdy", rld_rdy, tbl[n].err);
            chk("tbl_inv_rdy", inv_rdy, tbl[n].eir);
            chk("tbl_req_rdy", req_rdy, tbl[n].eqr);
            step();
            idle_in();
            if (acc_inv) step();
            if (tbl[n].f) repeat (128) step();
        end

        // Flush mid-traffic wipes a resident line.
        rld_val = 1; rld_ea = EA_D; step(); idle_in();
        req_val = 1; req_ea = EA_D; step(); idle_in();
        chk("pre_flush_hit", rsp_hit, 1);
        flush_val = 1; rld_val = 1; rld_ea = EA_A; req_val = 1; req_ea = EA_D;
        step(); idle_in();
        repeat (128) step();
        req_val = 1; req_ea = EA_D; step(); idle_in();
        chk("post_flush_miss", rsp_hit, 0);

        // Reset during the invalidate write cycle.
        rld_val = 1; rld_ea = EA_A; step(); idle_in();
        inv_val = 1; inv_ea = EA_A; step(); idle_in();
        rst = 1; step(); rst = 0;
        #1;
        chk("reinit_we", dir_wr_en, 4'hF);
        chk("reinit_adr0", dir_wr_adr, 0);
        repeat (128) step();

        // Randomized traffic over a small set of indices and tags.
        for (int k = 0; k < 1500; k++) begin
            flush_val = ($urandom_range(0, 99) == 0);
            rld_val   = ($urandom_range(0, 3) == 0);
            inv_val   = ($urandom_range(0, 3) == 0);
            req_val   = ($urandom_range(0, 1) == 0);
            rld_ea = {20'($urandom_range(0, 3)), 7'($urandom_range(0, 3)), 5'($urandom)};
            inv_ea = {20'($urandom_range(0, 3)), 7'($urandom_range(0, 3)), 5'($urandom)};
            req_ea = {20'($urandom_range(0, 3)), 7'($urandom_range(0, 3)), 5'($urandom)};
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 0; idle_in();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dcdir_ctl.md
Name: dcdir_ctl

Overview:
- Controller that sits directly in front of the L1 D-cache directory array (128 lines × 22 bits).
- Owns every directory read and write.
- Serves load/store tag lookups, reload fills, snoop/back-invalidates and flash-invalidate.
- Obeys the array's shared-address rule: any write cycle steals the read port, so only one op runs per cycle.

Parameters:
- LINES, 128, directory depth; must equal 2**IDX_W
- IDX_W, 7, index width, EA[OFFS_W+IDX_W-1:OFFS_W]
- OFFS_W, 5, line offset bits (32B line)
- TAG_W, 20, tag width, EA[31:OFFS_W+IDX_W]; entry width = TAG_W+2 = 22

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_val  in  1  lookup request
- req_ea  in  32  lookup effective address
- req_rdy  out  1  lookup accepted this cycle
- rsp_val  out  1  lookup result valid
- rsp_hit  out  1  lookup hit
- rsp_perr  out  1  parity error on a valid entry
- rld_val  in  1  reload fill request
- rld_ea  in  32  reload address
- rld_rdy  out  1  reload accepted
- inv_val  in  1  invalidate-by-address request
- inv_ea  in  32  invalidate address
- inv_rdy  out  1  invalidate accepted
- inv_done  out  1  invalidate completed (1-cycle pulse)
- inv_hit  out  1  with inv_done: a line was actually invalidated
- flush_val  in  1  flash-invalidate whole directory
- flush_rdy  out  1  flush accepted
- init_done  out  1  directory clean, controller operational
- dir_rd_adr  out  7  array read address
- dir_rd_dat  in  22  array read data (combinational)
- dir_wr_en  out  4  array write enable, always 4'b0000 or 4'b1111
- dir_wr_adr  out  7  array write address
- dir_wr_dat  out  22  array write data

Behaviour:
- Entry format: [21] valid, [20] even parity = ^tag, [19:0] tag. Write data is always a full entry; invalid entries are written as all-zero.
- States: INIT, IDLE, INV_WR.
- Reset (sync): state=INIT, cnt=0, rsp_val/rsp_hit/rsp_perr/inv_done/inv_hit/init_done=0. dir_wr_en=0 while rst=1. All pending work is dropped; an invalidate in flight is lost, with no inv_done.
- INIT:
  - Each cycle writes 22'b0 to address cnt, then cnt++.
  - After writing cnt=LINES-1, goes to IDLE. Exactly 128 write cycles.
  - init_done=0 throughout; it goes to 1 on IDLE entry and stays 1 until rst.
  - All rdy outputs are 0 in INIT.
- IDLE, fixed priority flush > reload > invalidate > lookup:
  - flush_rdy=1. rld_rdy=!flush_val. inv_rdy=!flush_val&&!rld_val. req_rdy=!flush_val&&!rld_val&&!inv_val.
  - Flush: go to INIT with cnt=0. init_done stays 1; flush is not reported as a reset.
  - Reload: one write cycle, data {1, ^tag, tag} to the rld_ea index. Stays in IDLE.
  - Invalidate read cycle: dir_rd_adr=index. Register match = valid && tag==inv tag; parity is ignored. Register the index, then go to INV_WR.
  - Lookup: dir_rd_adr=index, combinational compare.
    - Next cycle: rsp_val=1.
    - perr = valid && (^entry[20:0]).
    - hit = valid && tag match && !perr.
    - Latency 1. rsp_val pulses for one cycle per accepted request. Back-to-back lookups run at 1/cycle.
- INV_WR:
  - If the registered match is set, write 22'b0 to the registered index; otherwise no write.
  - inv_done=1 and inv_hit=match, both as 1-cycle registered pulses in this cycle.
  - Returns to IDLE. All rdy=0 in INV_WR.
- Address mux: in a write cycle dir_rd_adr=dir_wr_adr; otherwise it is the lookup/invalidate index (default req index). The array may tie read and write addresses.
- Ordering: a lookup in the cycle after a reload or invalidate write to the same index sees the new contents.
- Reload onto an already-valid index overwrites it; there is no hit check.
- rdy outputs are combinational; requesters hold val and address until rdy.

Test Plan:
- Deassert rst: 128 cycles of dir_wr_en=4'b1111 at addresses 0..127 with data 0 → init_done=1 on cycle 129; req_rdy=0 throughout INIT.
- Reload EA 0x12345_0A0 (idx 5, tag 0x12345); next cycle lookup same EA → rsp_val=1 and rsp_hit=1 one cycle later. Lookup 0x12346_0A0 → rsp_hit=0.
- Force dir_rd_dat to a valid entry with a flipped parity bit on a matching tag → rsp_perr=1, rsp_hit=0.
- Invalidate a resident EA → INV_WR writes 0 to idx, inv_done=inv_hit=1, next lookup misses. Invalidate a non-resident EA → no write, inv_done=1, inv_hit=0.
- rld_val, inv_val and req_val all asserted in IDLE → reload first, then invalidate (2 cycles), then lookup. Never a cycle with both a write and an accepted lookup.
- flush_val mid-traffic → 128 zero writes, then a prior hit EA misses. rst asserted during INV_WR → no inv_done, INIT restarts at 0.
